// File: rtl/instr_dispatch_queue.sv
// Per-core instruction dispatch: CORES independent FWFT FIFOs fed by one
// unicast/broadcast source. Optional per-core pop counters under DISPATCH_STATS_EN.
module instr_dispatch_queue #(
    parameter int CORES  = 3,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4,
    localparam int CW = (CORES > 1) ? $clog2(CORES) : 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    input  logic [WORD_W-1:0]         instr_word,
    input  logic [CW-1:0]             instr_core_sel,
    input  logic                      instr_bcast,
    output logic                      instr_ready,
    output logic [CORES-1:0]          core_instr_valid,
    output logic [CORES*WORD_W-1:0]   core_instr_word,
    input  logic [CORES-1:0]          core_ready_vec,
    output logic [CORES*(AW+1)-1:0]   q_count,
    output logic [CORES-1:0]          q_full,
    output logic                      sel_err
`ifdef DISPATCH_STATS_EN
    ,
    output logic [CORES*16-1:0]       stat_dispatched
`endif
);

    // Handshake: input side transfers when instr_valid && instr_ready at posedge;
    // core i transfers when core_instr_valid[i] && core_ready_vec[i] at posedge.

    logic [CORES-1:0] sel_onehot;
    logic [CORES-1:0] push;
    logic [CORES-1:0] pop;
    logic             sel_in_range;
    logic             sel_err_q, sel_err_d;

    assign sel_in_range = ({1'b0, instr_core_sel} < (CW+1)'(CORES));

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < CORES; i++) begin
            sel_onehot[i] = (instr_core_sel == CW'(i));
        end
    end

    // Out-of-range select has an all-zero one-hot, so it is always accepted (and dropped).
    always_comb begin
        instr_ready = 1'b0;
        if (instr_bcast) begin
            instr_ready = ~|q_full;
        end else begin
            instr_ready = ~|(q_full & sel_onehot);
        end
    end

    always_comb begin
        push = '0;
        if (instr_valid && instr_ready) begin
            push = instr_bcast ? {CORES{1'b1}} : sel_onehot;
        end
    end

    assign sel_err_d = instr_valid && !instr_bcast && !sel_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

    for (genvar g = 0; g < CORES; g++) begin : g_core
        logic [WORD_W-1:0] mem_q [DEPTH];
        logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
        logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
        logic [AW:0]       cnt_q, cnt_d;

        assign pop[g] = (cnt_q != '0) && core_ready_vec[g];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push[g]) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop[g]) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push[g], pop[g]})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Storage needs no reset: nothing is visible until the count says so.
        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem_q[wr_ptr_q] <= instr_word;
            end
        end

        assign core_instr_valid[g]                 = (cnt_q != '0);
        assign core_instr_word[g*WORD_W +: WORD_W] = mem_q[rd_ptr_q];
        assign q_count[g*(AW+1) +: (AW+1)]         = cnt_q;
        assign q_full[g]                           = (cnt_q == (AW+1)'(DEPTH));

`ifdef DISPATCH_STATS_EN
        logic [15:0] stat_q, stat_d;

        always_comb begin
            stat_d = stat_q;
            if (pop[g] && (stat_q != 16'hFFFF)) begin
                stat_d = stat_q + 16'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stat_q <= '0;
            end else begin
                stat_q <= stat_d;
            end
        end

        assign stat_dispatched[g*16 +: 16] = stat_q;
`endif
    end

endmodule

// File: tb/tb_instr_dispatch_queue.sv
// Self-checking bench for instr_dispatch_queue: directed scenarios plus random
// traffic compared against per-core queue model; covers DISPATCH_STATS_EN when defined.
module tb_instr_dispatch_queue;

    localparam int CORES  = 3;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = 2;
    localparam int AW     = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    instr_valid;
    logic [WORD_W-1:0]       instr_word;
    logic [CW-1:0]           instr_core_sel;
    logic                    instr_bcast;
    logic                    instr_ready;
    logic [CORES-1:0]        core_instr_valid;
    logic [CORES*WORD_W-1:0] core_instr_word;
    logic [CORES-1:0]        core_ready_vec;
    logic [CORES*(AW+1)-1:0] q_count;
    logic [CORES-1:0]        q_full;
    logic                    sel_err;
`ifdef DISPATCH_STATS_EN
    logic [CORES*16-1:0]     stat_dispatched;
`endif

    always #5 clk = ~clk;

    instr_dispatch_queue #(.CORES(CORES), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .instr_valid      (instr_valid),
        .instr_word       (instr_word),
        .instr_core_sel   (instr_core_sel),
        .instr_bcast      (instr_bcast),
        .instr_ready      (instr_ready),
        .core_instr_valid (core_instr_valid),
        .core_instr_word  (core_instr_word),
        .core_ready_vec   (core_ready_vec),
        .q_count          (q_count),
        .q_full           (q_full),
        .sel_err          (sel_err)
`ifdef DISPATCH_STATS_EN
        ,
        .stat_dispatched  (stat_dispatched)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one plain queue of words per core.
    logic [WORD_W-1:0] exp_q [CORES][$];
    logic              exp_sel_err;
    int unsigned       exp_stat [CORES];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_ready(input logic [CW-1:0] s, input logic b);
        if (b) begin
            for (int i = 0; i < CORES; i++) if (exp_q[i].size() == DEPTH) return 1'b0;
            return 1'b1;
        end
        if (int'(s) >= CORES) return 1'b1;
        return exp_q[s].size() < DEPTH;
    endfunction

    task automatic check_outputs();
        logic [CORES-1:0]        ev;
        logic [CORES-1:0]        ef;
        logic [CORES*(AW+1)-1:0] ec;
        ev = '0; ef = '0; ec = '0;
        for (int i = 0; i < CORES; i++) begin
            ev[i] = (exp_q[i].size() != 0);
            ef[i] = (exp_q[i].size() == DEPTH);
            ec[i*(AW+1) +: (AW+1)] = (AW+1)'(exp_q[i].size());
            if (ev[i]) check($sformatf("head%0d", i), core_instr_word[i*WORD_W +: WORD_W], exp_q[i][0]);
        end
        check("valid", core_instr_valid, ev);
        check("full", q_full, ef);
        check("count", q_count, ec);
        check("sel_err", sel_err, exp_sel_err);
        check("ready", instr_ready, model_ready(instr_core_sel, instr_bcast));
`ifdef DISPATCH_STATS_EN
        for (int i = 0; i < CORES; i++) check($sformatf("stat%0d", i), stat_dispatched[i*16 +: 16], exp_stat[i]);
`endif
    endtask

    // Called just after a negedge: drive, check settled outputs, clock, update model.
    task automatic cycle(input logic v, input logic [WORD_W-1:0] w, input logic [CW-1:0] s,
                         input logic b, input logic [CORES-1:0] rv);
        logic acc;
        instr_valid = v; instr_word = w; instr_core_sel = s; instr_bcast = b; core_ready_vec = rv;
        #1;
        check_outputs();
        acc = model_ready(s, b);
        @(posedge clk);
        for (int i = 0; i < CORES; i++) begin
            if (rv[i] && exp_q[i].size() > 0) begin
                void'(exp_q[i].pop_front());
                if (exp_stat[i] < 32'hFFFF) exp_stat[i]++;
            end
        end
        if (v && acc) begin
            if (b) begin
                for (int i = 0; i < CORES; i++) exp_q[i].push_back(w);
            end else if (int'(s) < CORES) begin
                exp_q[s].push_back(w);
            end
        end
        exp_sel_err = v && !b && (int'(s) >= CORES);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; instr_valid = 1'b0; core_ready_vec = '0; instr_bcast = 1'b0;
        @(posedge clk);
        for (int i = 0; i < CORES; i++) begin
            exp_q[i].delete();
            exp_stat[i] = 0;
        end
        exp_sel_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_word = '0; instr_core_sel = '0;
        instr_bcast = 1'b0; core_ready_vec = '0; exp_sel_err = 1'b0;
        @(negedge clk);
        do_reset();
        check_outputs();

        // Unicast to core 1
        cycle(1, 32'hA5A5_0001, 2'd1, 0, 3'b000);
        cycle(0, 32'h0, 2'd0, 0, 3'b000);
        check("t1_valid", core_instr_valid, 3'b010);
        check("t1_word", core_instr_word[WORD_W +: WORD_W], 32'hA5A5_0001);

        // Fill core 0, hold off the fifth, still accept core 2, drain in order
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1, 32'h1000_0000 + k, 2'd0, 0, 3'b000);
        check("t2_full", q_full[0], 1'b1);
        cycle(1, 32'h1000_0004, 2'd0, 0, 3'b000);
        cycle(1, 32'h2000_0000, 2'd2, 0, 3'b000);
        for (int k = 0; k < 5; k++) cycle(0, 32'h0, 2'd0, 0, 3'b001);
        check("t2_drained", q_count[0 +: 3], 3'd0);

        // Broadcast, then broadcast refused with queue 2 full
        do_reset();
        cycle(1, 32'hDEAD_BEEF, 2'd0, 1, 3'b000);
        check("t3_counts", q_count, {3'd1, 3'd1, 3'd1});
        for (int k = 0; k < 3; k++) cycle(1, 32'h3000_0000 + k, 2'd2, 0, 3'b000);
        cycle(1, 32'hBAD0_BAD0, 2'd0, 1, 3'b000);
        check("t3_refused", q_count, {3'd4, 3'd1, 3'd1});

        // Out-of-range select
        cycle(1, 32'h4444_4444, 2'd3, 0, 3'b000);
        check("t4_sel_err", sel_err, 1'b1);
        cycle(0, 32'h0, 2'd0, 0, 3'b000);
        check("t4_sel_err_clr", sel_err, 1'b0);

        // Steady push+pop on queue 1 across pointer wrap
        do_reset();
        cycle(1, 32'h5000_0000, 2'd1, 0, 3'b000);
        cycle(1, 32'h5000_0001, 2'd1, 0, 3'b000);
        for (int k = 2; k < 10; k++) cycle(1, 32'h5000_0000 + k, 2'd1, 0, 3'b010);
        check("t5_count", q_count[3 +: 3], 3'd2);

        // Reset mid-operation, then stats on core 2
        cycle(1, 32'h6000_0000, 2'd0, 1, 3'b000);
        do_reset();
        check_outputs();
        for (int k = 0; k < 3; k++) cycle(1, 32'h7000_0000 + k, 2'd2, 0, 3'b000);
        for (int k = 0; k < 3; k++) cycle(0, 32'h0, 2'd0, 0, 3'b100);
`ifdef DISPATCH_STATS_EN
        check("t6_stat2", stat_dispatched[32 +: 16], 16'd3);
`endif

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, $urandom, CW'($urandom_range(0, 3)),
                      $urandom_range(0, 7) == 0, CORES'($urandom_range(0, 7)));
            end
        end
        cycle(0, 32'h0, 2'd0, 0, 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
